// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and instruction encodings for the ALU issue sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP, GAP} seq_state_t;
  localparam int INST_W = 48;
  localparam logic [2:0] ALU_CLASS = 3'b100;
  localparam logic [3:0] ALU_MODE_REG = 4'b0100;
  localparam logic [3:0] ALU_MODE_IMM = 4'b1100;
  localparam logic [3:0] ADD = 4'b1000;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] MUL = 4'b1110;
  localparam logic [3:0] CMP = 4'b1001;
  function automatic logic is_alu_class(input logic [INST_W-1:0] inst);
    return inst[2:0] == ALU_CLASS;
  endfunction
endpackage

// File: rtl/alu_issue_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after ptr
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  // scan farthest to nearest so the nearest valid requester after ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = W'((int'(ptr) + k) % N);
        gnt = N'(1) << idx;
      end
    end
  end
endmodule

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: shares one ALU among NREQ requesters; ALU_SEQ_PERF_EN adds perf counters
module alu_issue_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*INST_W-1:0] req_inst,
  output logic [NREQ-1:0]        req_ready,
  output logic                   alu_en,
  output logic [INST_W-1:0]      alu_inst,
  input  logic                   alu_done,
  output logic [NREQ-1:0]        resp_valid,
  output logic                   resp_err,
  input  logic [NREQ-1:0]        resp_ready,
  output logic                   busy,
  output logic [31:0]            perf_issued,
  output logic [31:0]            perf_errors
);
  localparam int IW = $clog2(NREQ);
  seq_state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic [INST_W-1:0] inst_q, inst_d, sel_inst;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic resp_err_q, resp_err_d, any_req, resp_hs;
  rr_arbiter #(.N(NREQ), .W(IW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .gnt(gnt),
    .idx(gnt_idx)
  );
  assign any_req = |req_valid;
  assign sel_inst = req_inst[gnt_idx*INST_W +: INST_W];
  assign resp_hs = state_q == RESP && resp_ready[owner_q];
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // datapath registers: captured instruction, owner, status, fairness pointer, gap counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= IW'(NREQ - 1);
      owner_q <= '0;
      inst_q <= '0;
      resp_err_q <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      owner_q <= owner_d;
      inst_q <= inst_d;
      resp_err_q <= resp_err_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end
  // next state: grant in IDLE, one-cycle EXEC, hold RESP until owner accepts, then optional gap
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d = owner_q;
    inst_d = inst_q;
    resp_err_d = resp_err_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: if (any_req) begin
        inst_d = sel_inst;
        owner_d = gnt_idx;
        resp_err_d = !is_alu_class(sel_inst);
        state_d = resp_err_d ? RESP : EXEC;
      end
      EXEC: begin
        resp_err_d = ~alu_done;
        state_d = RESP;
      end
      RESP: if (resp_hs) begin
        rr_ptr_d = owner_q;
        gap_cnt_d = 4'(GAP);
        state_d = GAP == 0 ? IDLE : alu_seq_pkg::GAP;
      end
      default: begin
        gap_cnt_d = gap_cnt_q - 4'd1;
        if (gap_cnt_q == 4'd1) state_d = IDLE;
      end
    endcase
  end
  // outputs: ready only from IDLE out of reset, ALU driven only in EXEC, response one-hot to owner
  always_comb begin
    req_ready = (state_q == IDLE && rst) ? gnt : '0;
    alu_en = state_q == EXEC;
    alu_inst = alu_en ? inst_q : '0;
    resp_valid = state_q == RESP ? NREQ'(1) << owner_q : '0;
    resp_err = state_q == RESP && resp_err_q;
    busy = state_q != IDLE;
  end
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_issued_q, perf_errors_q;
  // count ALU issues and error completions, wrapping naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued_q <= '0;
      perf_errors_q <= '0;
    end else begin
      perf_issued_q <= perf_issued_q + 32'(state_q == EXEC);
      perf_errors_q <= perf_errors_q + 32'(resp_hs && resp_err_q);
    end
  end
  assign perf_issued = perf_issued_q;
  assign perf_errors = perf_errors_q;
`else
  assign perf_issued = '0;
  assign perf_errors = '0;
`endif
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb_alu_issue_sequencer: directed and random checks against a transaction-level model
module tb_alu_issue_sequencer;
  localparam int NREQ = 2;
  localparam int GAP = 1;
  localparam logic [47:0] ADD_INST = 48'h0000_0005_038C;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*48-1:0] req_inst;
  logic alu_en, alu_done, resp_err, busy;
  logic [47:0] alu_inst;
  logic [31:0] perf_issued, perf_errors;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last, cooldown, m_owner, m_iss, m_errs;
  bit m_busy, m_exec, m_err;
  logic [47:0] m_inst, r0, r1;
  logic [1:0] obs_ready, obs_rv;
  logic obs_en, obs_err, obs_busy;
  logic [47:0] obs_inst;
  int gq[$];
  int eq[$];

  alu_issue_sequencer #(.NREQ(NREQ), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_inst(req_inst), .req_ready(req_ready),
    .alu_en(alu_en), .alu_inst(alu_inst), .alu_done(alu_done), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_ready(resp_ready), .busy(busy),
    .perf_issued(perf_issued), .perf_errors(perf_errors)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_exec = 0; m_err = 0; cooldown = 0; last = NREQ - 1; m_iss = 0; m_errs = 0;
  endtask

  task automatic step(input logic [1:0] v, input logic [47:0] i0, input logic [47:0] i1,
                      input logic d, input logic [1:0] rr);
    int g;
    bit free;
    logic [1:0] e_ready, e_rv;
    req_valid = v; req_inst = {i1, i0}; alu_done = d; resp_ready = rr;
    #1;
    free = !m_busy && cooldown == 0;
    g = free ? pick(v) : -1;
    e_ready = g >= 0 ? 2'(1 << g) : 2'b00;
    e_rv = (m_busy && !m_exec) ? 2'(1 << m_owner) : 2'b00;
    obs_ready = req_ready; obs_en = alu_en; obs_inst = alu_inst;
    obs_rv = resp_valid; obs_err = resp_err; obs_busy = busy;
    check("req_ready", 64'(req_ready), 64'(e_ready));
    check("alu_en", 64'(alu_en), 64'(m_busy && m_exec));
    check("alu_inst", 64'(alu_inst), (m_busy && m_exec) ? 64'(m_inst) : 64'd0);
    check("resp_valid", 64'(resp_valid), 64'(e_rv));
    check("resp_err", 64'(resp_err), e_rv != 0 ? 64'(m_err) : 64'd0);
    check("busy", 64'(busy), 64'(!free));
`ifdef ALU_SEQ_PERF_EN
    check("perf_issued", 64'(perf_issued), 64'(m_iss));
    check("perf_errors", 64'(perf_errors), 64'(m_errs));
`endif
    if (g >= 0) begin
      m_busy = 1; m_owner = g; m_inst = g == 1 ? i1 : i0;
      m_exec = m_inst[2:0] == 3'b100; m_err = !m_exec;
    end else if (m_busy && m_exec) begin
      m_err = !d; m_exec = 0; m_iss++;
    end else if (m_busy && rr[m_owner]) begin
      m_busy = 0; last = m_owner; cooldown = GAP;
      if (m_err) m_errs++;
    end else if (cooldown > 0) cooldown--;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 48'd0, 48'd0, 1'b1, 2'b11);
  endtask

  initial begin
    rst = 1'b0; req_valid = 2'b11; req_inst = {ADD_INST, ADD_INST}; alu_done = 1'b1; resp_ready = 2'b11;
    #12;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_alu_en", 64'(alu_en), 64'd0);
    check("rst_alu_inst", 64'(alu_inst), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_perf", 64'({perf_issued, perf_errors}), 64'd0);
    req_valid = 2'b00;
    #10 rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      step(2'b11, ADD_INST, ADD_INST, 1'b1, 2'b11);
      if (obs_ready != 0) gq.push_back(obs_ready == 2'b10 ? 1 : 0);
      if (obs_en) eq.push_back(cyc - 1);
    end
    check("cont_grants", 64'(gq.size() >= 4), 64'd1);
    check("cont_g0", 64'(gq[0]), 64'd0);
    check("cont_g1", 64'(gq[1]), 64'd1);
    check("cont_g2", 64'(gq[2]), 64'd0);
    check("cont_g3", 64'(gq[3]), 64'd1);
    check("cont_pulses", 64'(eq.size() >= 4), 64'd1);
    for (int i = 1; i < 4; i++) check("cont_spacing", 64'(eq[i] - eq[i-1]), 64'd4);
    drain(4);
    step(2'b01, ADD_INST, 48'd0, 1'b1, 2'b01);
    check("add_ready", 64'(obs_ready), 64'h1);
    step(2'b00, 48'd0, 48'd0, 1'b1, 2'b01);
    check("add_en", 64'(obs_en), 64'h1);
    check("add_inst", 64'(obs_inst), 64'(ADD_INST));
    step(2'b00, 48'd0, 48'd0, 1'b1, 2'b01);
    check("add_rv", 64'(obs_rv), 64'h1);
    check("add_err", 64'(obs_err), 64'h0);
    check("add_en_off", 64'(obs_en), 64'h0);
    step(2'b00, 48'd0, 48'd0, 1'b1, 2'b01);
    check("add_gap_busy", 64'(obs_busy), 64'h1);
    drain(2);
    step(2'b01, 48'h1, 48'd0, 1'b1, 2'b01);
    check("nonalu_ready", 64'(obs_ready), 64'h1);
    step(2'b00, 48'd0, 48'd0, 1'b1, 2'b01);
    check("nonalu_en", 64'(obs_en), 64'h0);
    check("nonalu_rv", 64'(obs_rv), 64'h1);
    check("nonalu_err", 64'(obs_err), 64'h1);
    drain(3);
    step(2'b01, ADD_INST, 48'd0, 1'b0, 2'b00);
    step(2'b00, 48'd0, 48'd0, 1'b0, 2'b00);
    step(2'b00, 48'd0, 48'd0, 1'b0, 2'b01);
    check("notdone_err", 64'(obs_err), 64'h1);
    drain(3);
    step(2'b01, ADD_INST, ADD_INST, 1'b1, 2'b00);
    step(2'b10, ADD_INST, ADD_INST, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step(2'b10, ADD_INST, ADD_INST, 1'b1, 2'b10);
      check("bp_rv", 64'(obs_rv), 64'h1);
      check("bp_no_grant", 64'(obs_ready), 64'h0);
    end
    step(2'b10, ADD_INST, ADD_INST, 1'b1, 2'b01);
    drain(6);
    step(2'b01, ADD_INST, 48'd0, 1'b1, 2'b11);
    req_valid = 2'b00;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_en", 64'(alu_en), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rv", 64'(resp_valid), 64'd0);
    check("mid_rst_perf", 64'(perf_issued), 64'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    step(2'b11, ADD_INST, ADD_INST, 1'b1, 2'b11);
    check("post_rst_first", 64'(obs_ready), 64'h1);
    for (int i = 0; i < 400; i++) begin
      r0 = {16'($urandom), $urandom};
      r1 = {16'($urandom), $urandom};
      if ($urandom_range(0, 3) != 0) r0[2:0] = 3'b100;
      if ($urandom_range(0, 3) != 0) r1[2:0] = 3'b100;
      step(2'($urandom), r0, r1, $urandom_range(0, 3) != 0, 2'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Shares the single combinational ALU between NREQ requesters, e.g. the decode unit and a debug/microcode port.
- Accepts 48-bit ALU instructions over a valid/ready handshake and round-robin arbitrates between requesters.
- Drives the ALU enable for exactly one cycle per instruction, so the GPR write and the status update happen once.
- Enforces a post-issue gap so the ALU status flags are visible before the next issue, and returns a completion response to the owning requester.

Parameters:
NREQ, 2, number of requesters (2..8)
GAP, 1, idle cycles after each issue before the next grant (0..15)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
req_valid  in  NREQ  per-requester instruction valid
req_inst  in  NREQ*48  per-requester instruction; requester i uses bits [48*i+47:48*i]
req_ready  out  NREQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
alu_en  out  1  ALU enable
alu_inst  out  48  instruction presented to ALU
alu_done  in  1  ALU done, sampled during the EXEC cycle
resp_valid  out  NREQ  one-hot completion to owner, held until resp_ready
resp_err  out  1  completion status, valid with resp_valid: 1 = rejected or not executed
resp_ready  in  NREQ  per-requester response accept
busy  out  1  high in any state other than IDLE
perf_issued  out  32  issued-instruction count (optional feature)
perf_errors  out  32  error-completion count (optional feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=NREQ-1, inst_q=0, owner_q=0, gap_cnt=0.
  - All outputs 0 while in reset and on exit: req_ready, alu_en, alu_inst, resp_valid, resp_err, busy, perf counters.
- States are IDLE, EXEC, RESP, GAP.
- IDLE:
  - Grant g is the first i with req_valid[i] set, searching rr_ptr+1, rr_ptr+2, ... with wrap modulo NREQ.
  - req_ready[g]=1 combinationally; no ready is asserted when no requester is valid.
  - On transfer: inst_q<=req_inst[g], owner_q<=g.
    - If inst[2:0]==3'b100, go to EXEC.
    - Otherwise set resp_err_q=1 and go to RESP; the ALU is not touched.
- EXEC:
  - Lasts exactly 1 cycle: alu_en=1, alu_inst=inst_q.
  - resp_err_q <= ~alu_done. This covers an unsupported inst[3:0] mode.
  - Next state is RESP.
- alu_inst:
  - Equals inst_q in EXEC.
  - Is 0 in every other state, so there is no stray decode.
- RESP:
  - resp_valid[owner_q]=1 and resp_err=resp_err_q until resp_ready[owner_q]=1. Ready from any other requester is ignored.
  - On the handshake, rr_ptr<=owner_q.
    - If GAP=0, go to IDLE.
    - Otherwise gap_cnt<=GAP and go to GAP.
- GAP:
  - gap_cnt decrements by 1 each cycle; go to IDLE when gap_cnt==1.
  - No grants are made during GAP.
- Latency: accept to response = 2 cycles minimum (EXEC, then RESP). Back-to-back issue period = 3+GAP cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Losing requesters keep req_valid held; inputs are not latched until granted.
- Requester 0 wins the first arbitration after reset.
- Fairness: a requester waits at most NREQ-1 grants.
- Reset asserted mid-EXEC: alu_en drops immediately; the instruction is discarded with no response.
- req_valid may drop before a grant with no effect. After a grant, inst_q is the only copy used.

Optional Feature:
- Macro ALU_SEQ_PERF_EN.
- Defined:
  - perf_issued increments on each EXEC cycle.
  - perf_errors increments on each RESP handshake with resp_err=1.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package alu_seq_pkg:
  - Typedef seq_state_t {IDLE, EXEC, RESP, GAP}.
  - Constants INST_W=48, ALU_CLASS=3'b100, ALU_MODE_REG=4'b0100, ALU_MODE_IMM=4'b1100.
  - Opcode constants ADD=4'b1000, SUB=4'b0010, MUL=4'b1110, CMP=4'b1001.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req[N-1:0], ptr.
  - Outputs one-hot gnt and index.
  - Purely combinational; rr_ptr is owned by the sequencer.

Test Plan:
- Single ADD r3,#5: req_valid=2'b01, req_inst[0]=48'h0000_0005_038C.
  - req_ready=01 in cycle 0; alu_en=1 for exactly 1 cycle in cycle 1 with alu_inst=48'h0000_0005_038C.
  - Cycle 2: resp_valid=01, resp_err=0; busy stays high through GAP.
- Contention: both requesters valid continuously, GAP=1.
  - Grant order 0,1,0,1.
  - alu_en pulses exactly 4 cycles apart, each 1 cycle wide.
- Non-ALU instruction 48'h0000_0000_0001:
  - Accepted, alu_en never asserts, resp_valid with resp_err=1 one cycle after accept.
- ALU not done: alu_done tied 0 during EXEC → resp_err=1 on completion.
- Response backpressure: hold resp_ready=0 for 5 cycles.
  - resp_valid stays high and no new grant is made.
  - Asserting resp_ready[1] while the owner is 0 has no effect.
- Async reset mid-EXEC: drive rst=0 between edges.
  - alu_en=0 immediately, state IDLE, no resp_valid.
  - With ALU_SEQ_PERF_EN, perf_issued=0 after reset.
